// File: rtl/skipring_sched.sv
// Pattern scheduler for one skipring: plays a table of MASK patterns, each held
// for a programmable number of ring revolutions, with one-shot or looped playback.
//
// state | meaning
// IDLE  | ring disabled, waiting for START
// LOAD  | ring RST asserted for one cycle, first entry fetched
// RUN   | ring enabled, stepping entries on revolution boundaries
module skipring_sched #(
  parameter int             LEN    = 16,
  parameter int             AW     = 3,
  parameter int             RW     = 8,
  parameter logic [LEN-1:0] defSEL = LEN'(1)
) (
  input  logic           iCLK,
  input  logic           nRST,
  input  logic           START,
  input  logic           STOP,
  input  logic           LOOP,
  input  logic [AW:0]    NUM,
  input  logic           WR_EN,
  input  logic [AW-1:0]  WR_ADDR,
  input  logic [LEN-1:0] WR_MASK,
  input  logic [RW-1:0]  WR_REPS,
  input  logic           B0,
  output logic           E,
  output logic           LOAD,
  output logic [LEN-1:0] rSEL,
  output logic [LEN-1:0] MASK,
  output logic [AW-1:0]  IDX,
  output logic           BUSY,
  output logic           DONE
);

  localparam int DEPTH = 2**AW;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t         state_q;
  logic [LEN-1:0] mask_mem [DEPTH];
  logic [RW-1:0]  reps_mem [DEPTH];

  logic [RW-1:0]  rep_q;
  logic           b0_q;
  logic           stop_pend_q;
  logic           loop_q;
  logic [AW:0]    num_q;
  logic           e_q, load_q, busy_q, done_q;
  logic [LEN-1:0] mask_q;
  logic [AW-1:0]  idx_q;

  logic           wrap;
  logic [RW-1:0]  reps_cur;
  logic [RW-1:0]  rep_last;
  logic [AW-1:0]  idx_nxt;
  logic           last_entry;
  logic [AW:0]    num_d;

  always_ff @(posedge iCLK) begin
    if (WR_EN) begin
      mask_mem[WR_ADDR] <= WR_MASK;
      reps_mem[WR_ADDR] <= WR_REPS;
    end
  end

  // b0_q is forced high through LOAD so the start position is not a wrap
  assign wrap       = B0 & ~b0_q;
  assign reps_cur   = reps_mem[idx_q];
  assign rep_last   = (reps_cur == '0) ? '0 : reps_cur - RW'(1);
  assign idx_nxt    = idx_q + AW'(1);
  assign last_entry = ({1'b0, idx_q} == (num_q - (AW+1)'(1)));
  assign num_d      = (NUM > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : NUM;

  always_ff @(posedge iCLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_IDLE;
      rep_q       <= '0;
      b0_q        <= 1'b0;
      stop_pend_q <= 1'b0;
      loop_q      <= 1'b0;
      num_q       <= '0;
      e_q         <= 1'b0;
      load_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mask_q      <= '0;
      idx_q       <= '0;
    end else begin
      done_q <= 1'b0;
      b0_q   <= B0;
      case (state_q)
        S_IDLE: begin
          stop_pend_q <= 1'b0;
          if (START) begin
            if (NUM == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= S_LOAD;
              load_q  <= 1'b1;
              busy_q  <= 1'b1;
              num_q   <= num_d;
              loop_q  <= LOOP;
            end
          end
        end
        S_LOAD: begin
          b0_q        <= 1'b1;
          load_q      <= 1'b0;
          e_q         <= 1'b1;
          mask_q      <= mask_mem[0];
          idx_q       <= '0;
          rep_q       <= '0;
          stop_pend_q <= STOP;
          state_q     <= S_RUN;
        end
        S_RUN: begin
          if (wrap) begin
            if (stop_pend_q) begin
              state_q     <= S_IDLE;
              e_q         <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              stop_pend_q <= 1'b0;
            end else if (rep_q < rep_last) begin
              rep_q       <= rep_q + RW'(1);
              stop_pend_q <= STOP;
            end else begin
              rep_q       <= '0;
              stop_pend_q <= STOP;
              if (!last_entry) begin
                idx_q  <= idx_nxt;
                mask_q <= mask_mem[idx_nxt];
              end else if (loop_q) begin
                idx_q  <= '0;
                mask_q <= mask_mem[0];
              end else begin
                state_q     <= S_IDLE;
                e_q         <= 1'b0;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
                stop_pend_q <= 1'b0;
              end
            end
          end else if (STOP) begin
            stop_pend_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign E    = e_q;
  assign LOAD = load_q;
  assign rSEL = defSEL;
  assign MASK = mask_q;
  assign IDX  = idx_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_skipring_sched.sv
// Bench for skipring_sched: directed scenarios plus random traffic, all outputs
// compared every cycle against a revolution-counting reference model.
module tb_skipring_sched;

  localparam int LEN = 16;
  localparam int AW  = 3;
  localparam int RW  = 8;

  logic           iCLK = 1'b0;
  logic           nRST = 1'b0;
  logic           START = 1'b0, STOP = 1'b0, LOOP = 1'b0;
  logic [AW:0]    NUM = '0;
  logic           WR_EN = 1'b0;
  logic [AW-1:0]  WR_ADDR = '0;
  logic [LEN-1:0] WR_MASK = '0;
  logic [RW-1:0]  WR_REPS = '0;
  logic           B0 = 1'b0;
  logic           E, LOAD, BUSY, DONE;
  logic [LEN-1:0] rSEL, MASK;
  logic [AW-1:0]  IDX;

  skipring_sched #(.LEN(LEN), .AW(AW), .RW(RW), .defSEL(16'h0001)) dut (
    .iCLK(iCLK), .nRST(nRST), .START(START), .STOP(STOP), .LOOP(LOOP),
    .NUM(NUM), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_MASK(WR_MASK),
    .WR_REPS(WR_REPS), .B0(B0), .E(E), .LOAD(LOAD), .rSEL(rSEL),
    .MASK(MASK), .IDX(IDX), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 iCLK = ~iCLK;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: playback phase (0 idle, 1 load, 2 run), entry position and
  // number of revolutions completed on the current entry.
  int             m_phase, m_idx, m_cnt, m_num;
  bit             m_loop, m_pend, m_prevb0, m_done;
  logic [LEN-1:0] m_mask;
  logic [LEN-1:0] t_mask [8];
  int             t_reps [8];

  function automatic void model_reset();
    m_phase = 0; m_idx = 0; m_cnt = 0; m_num = 0;
    m_loop = 0; m_pend = 0; m_prevb0 = 0; m_done = 0; m_mask = '0;
  endfunction

  function automatic void model_step();
    bit wrap = B0 && !m_prevb0;
    int ph = m_phase;
    bit fin = 0;
    int n, need;
    m_done = 0;
    if (ph == 0) begin
      m_pend = 0;
      if (START) begin
        n = (int'(NUM) > 8) ? 8 : int'(NUM);
        if (n == 0) m_done = 1;
        else begin m_phase = 1; m_num = n; m_loop = LOOP; end
      end
    end else if (ph == 1) begin
      m_mask = t_mask[0]; m_idx = 0; m_cnt = 0; m_pend = STOP; m_phase = 2;
    end else begin
      if (wrap) begin
        if (m_pend) fin = 1;
        else begin
          m_cnt++;
          need = (t_reps[m_idx] == 0) ? 1 : t_reps[m_idx];
          if (m_cnt >= need) begin
            m_cnt = 0;
            if (m_idx + 1 < m_num) begin m_idx++; m_mask = t_mask[m_idx]; end
            else if (m_loop) begin m_idx = 0; m_mask = t_mask[0]; end
            else fin = 1;
          end
          m_pend = STOP;
        end
      end else if (STOP) m_pend = 1;
    end
    if (fin) begin m_phase = 0; m_done = 1; m_pend = 0; end
    m_prevb0 = (ph == 1) ? 1'b1 : B0;
    if (WR_EN) begin t_mask[WR_ADDR] = WR_MASK; t_reps[WR_ADDR] = int'(WR_REPS); end
  endfunction

  task automatic tick();
    @(posedge iCLK);
    model_step();
    #1;
    if (DONE === 1'b1) done_cnt++;
    check("E",    E,    m_phase == 2);
    check("LOAD", LOAD, m_phase == 1);
    check("BUSY", BUSY, m_phase != 0);
    check("DONE", DONE, m_done);
    check("MASK", MASK, m_mask);
    check("IDX",  IDX,  m_idx[AW-1:0]);
    check("rSEL", rSEL, 16'h0001);
    START = 1'b0; STOP = 1'b0; WR_EN = 1'b0;
  endtask

  task automatic rev(input int lo, input int hi);
    B0 = 1'b0; repeat (lo) tick();
    B0 = 1'b1; repeat (hi) tick();
  endtask

  task automatic wr(input int a, input logic [LEN-1:0] m, input int r);
    WR_EN = 1'b1; WR_ADDR = AW'(a); WR_MASK = m; WR_REPS = RW'(r);
    tick();
  endtask

  task automatic start(input int n, input bit lp);
    NUM = (AW+1)'(n); LOOP = lp; START = 1'b1;
    tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_E"},    E,    0);
    check({tag, "_LOAD"}, LOAD, 0);
    check({tag, "_MASK"}, MASK, 0);
    check({tag, "_IDX"},  IDX,  0);
    check({tag, "_BUSY"}, BUSY, 0);
    check({tag, "_DONE"}, DONE, 0);
  endtask

  logic [LEN-1:0] got_seq [6];
  logic [LEN-1:0] exp_seq [6];
  int d0;

  initial begin
    model_reset();
    for (int i = 0; i < 8; i++) begin t_mask[i] = '0; t_reps[i] = 1; end
    repeat (2) @(posedge iCLK);
    #1;
    check_zero("reset");
    nRST = 1'b1;
    for (int i = 0; i < 8; i++) wr(i, 16'h0000, 1);

    // basic one-shot sequence
    wr(0, 16'hCCCC, 2); wr(1, 16'h00FF, 1);
    d0 = done_cnt;
    start(2, 0);
    check("t1_load", LOAD, 1);
    tick();
    check("t1_load_low", LOAD, 0);
    check("t1_mask0", MASK, 16'hCCCC);
    rev(2, 2);
    check("t1_mask0b", MASK, 16'hCCCC);
    rev(2, 2);
    check("t1_mask1", MASK, 16'h00FF);
    rev(2, 2);
    check("t1_done", done_cnt - d0, 1);
    check("t1_e", E, 0);
    check("t1_mask_end", MASK, 16'h00FF);
    check("t1_idx_end", IDX, 1);

    // looped playback
    exp_seq[0] = 16'hCCCC; exp_seq[1] = 16'hCCCC; exp_seq[2] = 16'h00FF;
    exp_seq[3] = 16'hCCCC; exp_seq[4] = 16'hCCCC; exp_seq[5] = 16'h00FF;
    start(2, 1); tick();
    for (int k = 0; k < 6; k++) begin
      B0 = 1'b0; repeat (2) tick();
      got_seq[k] = MASK;
      B0 = 1'b1; repeat (2) tick();
      check("t2_busy", BUSY, 1);
    end
    for (int k = 0; k < 6; k++) check("t2_seq", got_seq[k], exp_seq[k]);
    STOP = 1'b1; tick();
    rev(2, 2);
    check("t2_stopped", BUSY, 0);

    // graceful stop, then stop+start together
    wr(0, 16'h1234, 5);
    for (int v = 0; v < 2; v++) begin
      start(1, 0); tick();
      rev(2, 2);
      B0 = 1'b0; tick();
      STOP = 1'b1;
      if (v == 1) begin START = 1'b1; NUM = 1; end
      tick(); tick();
      check("t3_still_busy", BUSY, 1);
      d0 = done_cnt;
      rev(2, 2);
      check("t3_done", done_cnt - d0, 1);
      check("t3_idx", IDX, 0);
      check("t3_idle", BUSY, 0);
    end

    // NUM=0, zero reps, B0 rising right after LOAD
    d0 = done_cnt;
    start(0, 0);
    check("t4_num0_done", DONE, 1);
    check("t4_num0_busy", BUSY, 0);
    tick();
    check("t4_num0_busy2", BUSY, 0);
    check("t4_num0_pulses", done_cnt - d0, 1);
    wr(0, 16'h5555, 0);
    start(1, 0); tick();
    d0 = done_cnt;
    rev(2, 2);
    check("t4_reps0", done_cnt - d0, 1);
    B0 = 1'b0;
    start(1, 0);
    tick();
    B0 = 1'b1;
    repeat (4) tick();
    check("t4_b0high_busy", BUSY, 1);
    d0 = done_cnt;
    rev(2, 2);
    check("t4_b0high_done", done_cnt - d0, 1);

    // live write of the active entry
    wr(0, 16'hCCCC, 2); wr(1, 16'h00FF, 1);
    start(2, 1); tick();
    B0 = 1'b0; tick();
    wr(0, 16'hAAAA, 2);
    check("t5_hold", MASK, 16'hCCCC);
    rev(1, 2);
    check("t5_hold2", MASK, 16'hCCCC);
    rev(2, 2);
    check("t5_e1", MASK, 16'h00FF);
    rev(2, 2);
    check("t5_refetch", MASK, 16'hAAAA);
    STOP = 1'b1; tick();
    rev(2, 2);

    // async reset mid-run
    start(2, 1); tick();
    rev(2, 2);
    B0 = 1'b0; tick();
    #2 nRST = 1'b0;
    #1 check_zero("t6");
    model_reset();
    #4 nRST = 1'b1;
    tick();

    // random traffic
    for (int i = 0; i < 8; i++) wr(i, LEN'($urandom), $urandom_range(0, 3));
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) B0 = ~B0;
      if ($urandom_range(0, 19) == 0) begin
        START = 1'b1; NUM = (AW+1)'($urandom_range(0, 15)); LOOP = 1'($urandom);
      end
      if ($urandom_range(0, 39) == 0) STOP = 1'b1;
      if ($urandom_range(0, 9) == 0) begin
        WR_EN = 1'b1; WR_ADDR = AW'($urandom); WR_MASK = LEN'($urandom);
        WR_REPS = RW'($urandom_range(0, 3));
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
